// File: rtl/credit_display_scan.sv
// credit_display_scan: binary credit value to 4-digit BCD, multiplexed 7-seg scan.
// Ports: clk, rst_n (async low), value[13:0], load -> busy, digit_nibble[3:0],
// digit_en, anode[3:0] (active-low, bit0 = ones). Option: LEADING_ZERO_BLANK_EN.
module credit_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic [3:0]  digit_nibble,
    output logic        digit_en,
    output logic [3:0]  anode
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [19:0] DIV_M1 = 20'(REFRESH_DIV - 1);

    state_t      r_state;
    logic        r_busy;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_bitcnt;
    logic [15:0] r_disp;

    logic [19:0] r_cnt;
    logic [1:0]  r_idx;

    logic [3:0]  r_nibble;
    logic        r_en;
    logic [3:0]  r_anode;

    logic [13:0] w_sat;
    logic [15:0] w_adj;
    logic [15:0] w_disp_next;
    logic        w_wrap;
    logic [1:0]  w_idx_next;
    logic [3:0]  w_nib_sel;
    logic        w_blank;

    assign w_sat = (value > 14'd9999) ? 14'd9999 : value;

    // add-3 correction applied to every BCD digit before each shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // conversion FSM; display registers only change in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_disp   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin    <= w_sat;
                        r_bcd    <= '0;
                        r_bitcnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    r_bcd    <= {w_adj[14:0], r_bin[13]};
                    r_bin    <= {r_bin[12:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd13)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    r_disp  <= r_bcd;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // scan timing runs free of the conversion FSM
    assign w_wrap     = (r_cnt == DIV_M1);
    assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_wrap ? 20'd0 : r_cnt + 20'd1;
            r_idx <= w_idx_next;
        end
    end

    // outputs are built from next-cycle index and digits so they
    // move in the same edge as a scan step or a commit
    assign w_disp_next = (r_state == COMMIT) ? r_bcd : r_disp;
    assign w_nib_sel   = w_disp_next[w_idx_next*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank = 1'b0;
        unique case (w_idx_next)
            2'd0: w_blank = 1'b0;
            2'd1: w_blank = (w_disp_next[15:4] == 12'd0);
            2'd2: w_blank = (w_disp_next[15:8] == 8'd0);
            2'd3: w_blank = (w_disp_next[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nibble <= 4'b0000;
            r_en     <= 1'b1;
            r_anode  <= 4'b1110;
        end else begin
            r_nibble <= w_nib_sel;
            r_en     <= ~w_blank;
            r_anode  <= w_blank ? 4'b1111 : ~(4'b0001 << w_idx_next);
        end
    end

    assign busy         = r_busy;
    assign digit_nibble = r_nibble;
    assign digit_en     = r_en;
    assign anode        = r_anode;

endmodule

// File: tb/tb_credit_display_scan.sv
// tb_credit_display_scan: directed + random loads against an arithmetic model.
// Scan position and displayed digits are derived from edge counts and decimal math.
module tb_credit_display_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  digit_nibble;
    logic        digit_en;
    logic [3:0]  anode;

    int total = 0;
    int bad = 0;
    int ecount = 0;
    int disp_val = 0;
    logic exp_busy = 1'b0;

    credit_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .load(load),
        .busy(busy),
        .digit_nibble(digit_nibble),
        .digit_en(digit_en),
        .anode(anode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int idx;
        int p;
        int dig;
        bit blank;
        logic [3:0] an;
        idx = (ecount / DIV) % 4;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        dig = (disp_val / p) % 10;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx > 0) && (disp_val < p);
`endif
        an = 4'b1111;
        if (!blank) an[idx] = 1'b0;
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, exp_busy});
        chk({tag, ".anode"}, anode, an);
        chk({tag, ".en"}, {3'b0, digit_en}, {3'b0, ~blank});
        if (!blank)
            chk({tag, ".nib"}, digit_nibble, 4'(dig));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            check_all("idle");
            @(negedge clk);
        end
    endtask

    // mode 0: single pulse, 1: second load next cycle, 2: load held through commit
    task automatic do_load(input int v, input int mode, input int v2);
        value = 14'(v);
        load = 1'b1;
        @(negedge clk);
        if (mode == 0) load = 1'b0;
        else value = 14'(v2);
        exp_busy = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            check_all("conv");
            @(negedge clk);
            if (t == 1 && mode == 1) load = 1'b0;
        end
        if (mode == 2) load = 1'b0;
        exp_busy = 1'b0;
        disp_val = (v > 9999) ? 9999 : v;
        check_all("commit");
    endtask

    initial begin
        rst_n = 1'b0;
        value = '0;
        load = 1'b0;
        #12;
        chk("rst.anode", anode, 4'b1110);
        chk("rst.nib", digit_nibble, 4'b0000);
        chk("rst.en", {3'b0, digit_en}, 4'b0001);
        chk("rst.busy", {3'b0, busy}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        do_load(1234, 0, 0);
        idle(17);
        do_load(16383, 0, 0);
        idle(9);
        do_load(42, 1, 77);
        idle(16);
        do_load(9999, 2, 555);
        idle(5);
        do_load(10000, 0, 0);
        idle(3);
        do_load(7, 0, 0);
        idle(16);
        do_load(0, 0, 0);
        idle(16);
        do_load(305, 0, 0);
        idle(16);

        for (int r = 0; r < 8; r++) begin
            do_load(int'($urandom_range(0, 16383)), 0, 0);
            idle(int'($urandom_range(0, 9)));
        end

        do_load(1234, 0, 0);
        idle(6);
        value = 14'd5678;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        exp_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check_all("pre_rst");
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_busy = 1'b0;
        disp_val = 0;
        chk("arst.busy", {3'b0, busy}, 4'b0000);
        chk("arst.anode", anode, 4'b1110);
        chk("arst.nib", digit_nibble, 4'b0000);
        chk("arst.en", {3'b0, digit_en}, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        do_load(88, 0, 0);
        idle(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
